// File: rtl/scratchpad_mem.sv
// 64-bit scratchpad: low words hit a local array, others go to backing memory.
// Define SPM_REMAP_EN to present forwarded addresses zero-based (addr - SPM_DEPTH).
module scratchpad_mem #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int SPM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  re,
    input  logic                  we,
    output logic                  ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  mem_re,
    output logic                  mem_we,
    input  logic                  mem_ready
);

    localparam int IDX_W = $clog2(SPM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(SPM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_e;

    state_e                  state_q, state_d;
    logic                    ready_q, ready_d;
    logic                    rd_q, rd_d;
    logic                    mem_re_q, mem_re_d;
    logic                    mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_din_q, mem_din_d;
    logic [DATA_WIDTH-1:0]   arr_q [SPM_DEPTH];
    logic                    arr_we;
    logic                    is_local;
    logic [IDX_W-1:0]        idx;
    logic [ADDR_WIDTH-1:0]   fwd_addr;

    assign is_local = addr < DEPTH_A;
    assign idx      = addr[IDX_W-1:0];

`ifdef SPM_REMAP_EN
    assign fwd_addr = addr - DEPTH_A;
`else
    assign fwd_addr = addr;
`endif

    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        rd_d       = rd_q;
        mem_re_d   = mem_re_q;
        mem_we_d   = mem_we_q;
        dout_d     = dout_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        arr_we     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (re || we) begin
                    if (is_local) begin
                        // A combined request is treated as a write only
                        arr_we = we;
                        if (re && !we) dout_d = arr_q[idx];
                    end else begin
                        mem_addr_d = fwd_addr;
                        mem_din_d  = din;
                        mem_we_d   = we;
                        mem_re_d   = re && !we;
                        rd_d       = re && !we;
                        ready_d    = 1'b0;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                mem_re_d = 1'b0;
                mem_we_d = 1'b0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (mem_ready) begin
                    if (rd_q) dout_d = mem_dout;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b1;
            rd_q       <= 1'b0;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            dout_q     <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            rd_q       <= rd_d;
            mem_re_q   <= mem_re_d;
            mem_we_q   <= mem_we_d;
            dout_q     <= dout_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    // Array contents are not cleared by reset
    always_ff @(posedge clk) begin
        if (rst && arr_we) arr_q[idx] <= din;
    end

    assign dout     = dout_q;
    assign ready    = ready_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_re   = mem_re_q;
    assign mem_we   = mem_we_q;

endmodule

// File: tb/tb_scratchpad_mem.sv
// Directed bench for scratchpad_mem with a 150-cycle backing memory model.
// Expected forwarded addresses follow SPM_REMAP_EN when it is defined.
module tb_scratchpad_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] addr = '0;
    logic [63:0] din = '0;
    logic [63:0] dout;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic        ready;
    logic [63:0] mem_addr;
    logic [63:0] mem_din;
    logic [63:0] mem_dout = '0;
    logic        mem_re;
    logic        mem_we;
    logic        mem_ready = 1'b1;

    int checks = 0;
    int failures = 0;

    logic [63:0] bmem [256];
    int          busy_cnt = 0;

`ifdef SPM_REMAP_EN
    localparam logic [63:0] EXP_257 = 64'd1;
`else
    localparam logic [63:0] EXP_257 = 64'd257;
`endif

    always #5 clk = ~clk;

    scratchpad_mem dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .din       (din),
        .dout      (dout),
        .re        (re),
        .we        (we),
        .ready     (ready),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_ready (mem_ready)
    );

    // Backing memory: samples a strobe while idle, busy for 150 cycles
    always @(posedge clk) begin
        if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) mem_ready <= 1'b1;
        end else if (mem_re || mem_we) begin
            mem_ready <= 1'b0;
            busy_cnt  <= 150;
            if (mem_we) bmem[mem_addr[7:0]] <= mem_din;
            if (mem_re) mem_dout <= bmem[mem_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int max);
        int n = 0;
        while (ready !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ready", {63'd0, ready}, 64'd1);
    endtask

    task automatic local_op(input logic r, input logic w,
                            input logic [63:0] a, input logic [63:0] d);
        re = r; we = w; addr = a; din = d;
        @(negedge clk);
        re = 1'b0; we = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) bmem[i] = '0;

        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk("rst_ready", {63'd0, ready}, 64'd1);
        chk("rst_mem_ready", {63'd0, mem_ready}, 64'd1);
        chk("rst_dout", dout, 64'd0);
        chk("rst_strobes", {62'd0, mem_re, mem_we}, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);

        local_op(1'b0, 1'b1, 64'd1, 64'h0123456789abcdef);
        chk("lw_ready", {63'd0, ready}, 64'd1);
        chk("lw_nostrobe", {62'd0, mem_re, mem_we}, 64'd0);
        chk("lw_dout_hold", dout, 64'd0);

        local_op(1'b1, 1'b0, 64'd1, 64'd0);
        chk("lr_dout", dout, 64'h0123456789abcdef);
        chk("lr_ready", {63'd0, ready}, 64'd1);

        local_op(1'b1, 1'b1, 64'd2, 64'h55aa);
        chk("both_dout_hold", dout, 64'h0123456789abcdef);
        local_op(1'b1, 1'b0, 64'd2, 64'd0);
        chk("both_wrote", dout, 64'h55aa);

        local_op(1'b0, 1'b1, 64'd255, 64'hfeed);
        chk("b255_ready", {63'd0, ready}, 64'd1);
        chk("b255_nostrobe", {62'd0, mem_re, mem_we}, 64'd0);
        local_op(1'b1, 1'b0, 64'd255, 64'd0);
        chk("b255_dout", dout, 64'hfeed);

        // Forwarded write
        local_op(1'b0, 1'b1, 64'd257, 64'd123);
        chk("fw_ready_low", {63'd0, ready}, 64'd0);
        chk("fw_mem_we", {62'd0, mem_re, mem_we}, 64'd1);
        chk("fw_mem_addr", mem_addr, EXP_257);
        chk("fw_mem_din", mem_din, 64'd123);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("fw_busy", {63'd0, ready}, 64'd0);
            if (i == 0) chk("fw_pulse_end", {62'd0, mem_re, mem_we}, 64'd0);
            if (i == 10) begin
                we = 1'b1; addr = 64'd1; din = 64'hffff;
            end else begin
                we = 1'b0;
            end
        end
        wait_ready(400);
        chk("fw_dout_hold", dout, 64'hfeed);

        local_op(1'b1, 1'b0, 64'd1, 64'd0);
        chk("ignored_req", dout, 64'h0123456789abcdef);

        // Forwarded read
        local_op(1'b1, 1'b0, 64'd257, 64'd0);
        chk("fr_ready_low", {63'd0, ready}, 64'd0);
        chk("fr_mem_re", {62'd0, mem_re, mem_we}, 64'd2);
        chk("fr_mem_addr", mem_addr, EXP_257);
        @(negedge clk);
        chk("fr_pulse_end", {62'd0, mem_re, mem_we}, 64'd0);
        wait_ready(400);
        chk("fr_dout", dout, 64'd123);

        // Boundary: SPM_DEPTH is forwarded
        local_op(1'b0, 1'b1, 64'd256, 64'd7);
        chk("b256_fwd", {63'd0, ready}, 64'd0);
        chk("b256_mem_we", {62'd0, mem_re, mem_we}, 64'd1);
        wait_ready(400);

        // Reset during WAIT
        local_op(1'b1, 1'b0, 64'd300, 64'd0);
        repeat (20) @(negedge clk);
        chk("rw_in_wait", {63'd0, ready}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("rw_ready", {63'd0, ready}, 64'd1);
        chk("rw_strobes", {62'd0, mem_re, mem_we}, 64'd0);
        chk("rw_dout", dout, 64'd0);
        local_op(1'b0, 1'b1, 64'd3, 64'h3333);
        local_op(1'b1, 1'b0, 64'd3, 64'd0);
        chk("rw_local", dout, 64'h3333);
        chk("rw_local_ready", {63'd0, ready}, 64'd1);
        repeat (200) @(negedge clk);
        chk("rw_discard", dout, 64'h3333);
        chk("rw_idle", {63'd0, ready}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
